// File: rtl/lfsr.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lfsr -- parameterisable Fibonacci linear-feedback shift register.
//
// The register shifts toward the MSB on every enabled rising edge and
// inserts the feedback bit at bit 0. The feedback bit is the XOR of all
// state bits selected by TAPS.
//
// Parameters (positional order WIDTH, TAPS, SEED, e.g. #(3, 3'b101)):
//   WIDTH : register length, 2..32
//   TAPS  : WIDTH-bit feedback mask, bit i set -> state[i] feeds the XOR
//   SEED  : reset/reload value; an all-zero SEED is replaced by all-ones
//
// Ports:
//   clk      : in  - clock, rising edge active
//   reset    : in  - asynchronous reset, active low; loads the seed
//   enable   : in  - advance one step per rising edge while high
//   lfsr_out : out - current register state, straight from the flops
//
// Build option:
//   LFSR_LOCKUP_RECOVERY_EN - when defined, an all-zero state seen on an
//   enabled edge reloads the seed. When undefined, the all-zero state
//   persists until reset and no recovery logic exists.
// ---------------------------------------------------------------------------
module lfsr #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] lfsr_out
);

    // An all-zero seed would lock the register up forever, so it is
    // replaced by all-ones at elaboration.
    localparam logic [WIDTH-1:0] EFF_SEED = (SEED == '0) ? '1 : SEED;

    // Reject configurations that cannot form a working register.
    generate
        if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
            $error("lfsr: WIDTH=%0d is outside the legal range 2..32", WIDTH);
        end
        if (TAPS == '0) begin : g_bad_taps
            $error("lfsr: TAPS must select at least one feedback bit");
        end
    endgenerate

    logic [WIDTH-1:0] state;
    logic             fb;

    // Parity of the tapped bits.
    assign fb = ^(state & TAPS);

`ifdef LFSR_LOCKUP_RECOVERY_EN
    logic lockup;

    // Zero is a fixed point of XOR feedback; detecting it is the only way out.
    assign lockup = (state == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of state, whatever the statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EFF_SEED;
        end else if (enable) begin
            if (lockup) begin
                state <= EFF_SEED;
            end else begin
                state <= {state[WIDTH-2:0], fb};
            end
        end
    end
`else
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of state, whatever the statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EFF_SEED;
        end else if (enable) begin
            state <= {state[WIDTH-2:0], fb};
        end
    end
`endif

    // Output is the flop bank itself: no path from enable to lfsr_out.
    assign lfsr_out = state;

endmodule

// File: tb/tb_lfsr.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_lfsr -- scoreboard bench for lfsr.
//
// Four instances run side by side:
//   0: #(3, 3'b101)                         short sequence / enable / reset
//   1: defaults (8-bit, taps B8)             period and no-zero behaviour
//   2: WIDTH=4, TAPS=1001, SEED=0            seed substitution
//   3: WIDTH=2, TAPS=01, SEED=10             reaches the all-zero state
// The stimulus process updates a parity-based reference model and queues
// expected outputs; the monitor pops and compares after each clock edge
// (or after a mid-cycle probe for the asynchronous-reset check).
// ---------------------------------------------------------------------------
module tb_lfsr;

    typedef struct {
        int unsigned id;
        logic [31:0] exp;
        string       tag;
    } exp_t;

`ifdef LFSR_LOCKUP_RECOVERY_EN
    localparam bit RECOV = 1'b1;
`else
    localparam bit RECOV = 1'b0;
`endif

    exp_t        sb_q[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic       clk = 1'b0;
    logic       probe = 1'b0;
    logic [3:0] rst_v;
    logic [3:0] en_v;
    logic [2:0] out3;
    logic [7:0] out8;
    logic [3:0] outz;
    logic [1:0] outl;

    always #5 clk = ~clk;

    lfsr #(3, 3'b101) u_w3 (
        .clk(clk), .reset(rst_v[0]), .enable(en_v[0]), .lfsr_out(out3)
    );
    lfsr u_def (
        .clk(clk), .reset(rst_v[1]), .enable(en_v[1]), .lfsr_out(out8)
    );
    lfsr #(.WIDTH(4), .TAPS(4'b1001), .SEED(4'b0000)) u_seed0 (
        .clk(clk), .reset(rst_v[2]), .enable(en_v[2]), .lfsr_out(outz)
    );
    lfsr #(.WIDTH(2), .TAPS(2'b01), .SEED(2'b10)) u_lock (
        .clk(clk), .reset(rst_v[3]), .enable(en_v[3]), .lfsr_out(outl)
    );

    // ---------------- reference model ----------------
    int unsigned m_width[4] = '{3, 8, 4, 2};
    logic [31:0] m_taps[4]  = '{32'h5, 32'hB8, 32'h9, 32'h1};
    // Effective seeds: instance 2 has SEED=0, so all-ones applies.
    logic [31:0] m_seed[4]  = '{32'h7, 32'hFF, 32'hF, 32'h2};
    logic [31:0] m_state[4];

    // Next value: shift left, append parity of tapped bits, trim to width.
    function automatic logic [31:0] ref_next(int unsigned id, logic [31:0] s);
        logic [31:0] mask;
        int unsigned ones;
        mask = (32'h1 << m_width[id]) - 32'h1;
        if (s == 32'h0) return RECOV ? m_seed[id] : 32'h0;
        ones = $countones(s & m_taps[id]);
        return ((s << 1) | 32'(ones % 2)) & mask;
    endfunction

    function automatic logic [31:0] dut_out(int unsigned id);
        case (id)
            0:       return 32'(out3);
            1:       return 32'(out8);
            2:       return 32'(outz);
            default: return 32'(outl);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input int unsigned id, input logic [31:0] exp, input string tag);
        exp_t e;
        e.id  = id;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // One clock cycle: drive inputs at the falling edge, advance the model,
    // queue what every instance must show after the next rising edge.
    task automatic tick(input logic [3:0] en, input logic [3:0] rstn, input string tag);
        @(negedge clk);
        en_v  = en;
        rst_v = rstn;
        for (int i = 0; i < 4; i++) begin
            if (!rstn[i])  m_state[i] = m_seed[i];
            else if (en[i]) m_state[i] = ref_next(i, m_state[i]);
            push(i, m_state[i], tag);
        end
    endtask

    // ---------------- monitor ----------------
    int unsigned period_steps = 0;
    int unsigned first_return = 0;
    bit          zero_seen = 1'b0;

    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(posedge clk or posedge probe);
            #1;
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = dut_out(e.id);
                check($sformatf("%s dut%0d", e.tag, e.id), act, e.exp);
                if (e.id == 1 && e.tag == "period") begin
                    period_steps++;
                    if (act == 32'h0) zero_seen = 1'b1;
                    if (act == 32'hFF && first_return == 0) first_return = period_steps;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic [2:0] seq3[8] = '{3'b111, 3'b110, 3'b101, 3'b010, 3'b100, 3'b001, 3'b011, 3'b111};

    initial begin
        rst_v = 4'b0000;
        en_v  = 4'b0000;
        for (int i = 0; i < 4; i++) m_state[i] = m_seed[i];

        // Reset held: seeds visible, seed-0 instance shows all-ones.
        tick(4'b0000, 4'b0000, "reset");
        push(2, 32'hF, "seed0_ones");
        tick(4'b1111, 4'b0000, "reset_en");

        // Release with enable low, then the documented 3-bit sequence.
        tick(4'b0000, 4'b1111, "release");
        push(0, 32'(seq3[0]), "seq_w3");
        for (int k = 1; k < 8; k++) begin
            tick(4'b0001, 4'b1111, "seq");
            push(0, 32'(seq3[k]), "seq_w3");
        end

        // Restart, step to 010, hold three cycles, resume at 100.
        tick(4'b0000, 4'b1110, "reset_w3");
        tick(4'b0000, 4'b1111, "release_w3");
        for (int k = 0; k < 3; k++) tick(4'b0001, 4'b1111, "run");
        for (int k = 0; k < 3; k++) begin
            tick(4'b0000, 4'b1111, "hold");
            push(0, 32'h2, "hold_010");
        end
        tick(4'b0001, 4'b1111, "resume");
        push(0, 32'h4, "resume_100");

        // Asynchronous reset between edges takes effect at once.
        @(negedge clk);
        #2;
        rst_v[0]   = 1'b0;
        m_state[0] = m_seed[0];
        push(0, 32'h7, "async_rst");
        probe = 1'b1;
        #1;
        probe = 1'b0;

        // Reset low with enable high: reset wins on the edge.
        tick(4'b0001, 4'b1110, "rst_over_step");
        push(0, 32'h7, "rst_wins");
        tick(4'b0000, 4'b1111, "post_rst_idle");
        tick(4'b0001, 4'b1111, "first_step");
        push(0, 32'h6, "first_step_110");

        // 2-bit instance: 10 -> 00, then recovery or lock-up.
        tick(4'b1000, 4'b1111, "lock");
        push(3, 32'h0, "lock_zero");
        tick(4'b1000, 4'b1111, "lock");
        push(3, RECOV ? 32'h2 : 32'h0, "lock_next");

        // Default instance from reset, 300 enabled steps.
        tick(4'b0000, 4'b1101, "reset_def");
        for (int k = 0; k < 300; k++) tick(4'b0010, 4'b1111, "period");

        // Random enables and occasional resets on every instance.
        for (int k = 0; k < 200; k++) begin
            logic [3:0] en;
            logic [3:0] rn;
            en = 4'($urandom);
            for (int i = 0; i < 4; i++) rn[i] = ($urandom_range(0, 15) != 0);
            tick(en, rn, "rand");
        end

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(sb_q.size()), 32'h0);
        check("period_255", 32'(first_return), 32'd255);
        check("never_zero", 32'(zero_seen), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr.md
LFSR -- requirements
Module: lfsr

Interface
REQ-001 Parameter WIDTH, default 8, is the register length in bits and SHALL be legal from 2 to 32 inclusive.
REQ-002 Parameter TAPS, default 8'hB8, is a WIDTH-bit feedback mask in which bit i set means state[i] feeds the XOR.
REQ-003 Parameter SEED, default all-ones of WIDTH bits, is the reset and reload value of the register.
REQ-004 Parameter order SHALL be WIDTH, TAPS, SEED so that positional overrides such as (3, 3'b101) are legal.
REQ-005 Port clk, input, 1 bit: the single clock, active on the rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port enable, input, 1 bit: advances the register one step per rising clk edge while high.
REQ-008 Port lfsr_out, output, WIDTH bits: the current register state, driven directly from flops.

Function
REQ-009 The block SHALL be a Fibonacci LFSR with feedback fb = XOR-reduction of (state AND TAPS).
REQ-010 On each rising clk edge with enable high and reset high, next state SHALL be {state[WIDTH-2:0], fb}, i.e. shift toward the MSB and insert fb at bit 0.
REQ-011 With enable low, state SHALL hold its value.
REQ-012 Latency SHALL be one cycle: lfsr_out reflects the new state immediately after the advancing edge, with no combinational path from enable to lfsr_out.
REQ-013 If SEED is all-zero, the effective seed SHALL be all-ones, substituted at elaboration.
REQ-014 Elaboration SHALL fail with an error message if WIDTH is outside 2..32 or TAPS is zero.
REQ-015 For WIDTH=3, TAPS=3'b101 and SEED=3'b111, the sequence SHALL be 111, 110, 101, 010, 100, 001, 011, 111 (period 7).
REQ-016 For maximal-length TAPS, the period SHALL be 2^WIDTH-1 and the all-zero state SHALL never be produced.
REQ-017 The block SHALL have no handshake: every enabled edge produces exactly one step.

Reset
REQ-018 While reset is low, state and lfsr_out SHALL equal the effective seed asynchronously, independent of clk and enable.
REQ-019 Reset asserted mid-sequence SHALL override any step on the same edge.
REQ-020 After reset deasserts, the first step SHALL occur on the first rising clk edge with enable high.

Configuration
REQ-021 Macro LFSR_LOCKUP_RECOVERY_EN SHALL control lock-up recovery.
REQ-022 With LFSR_LOCKUP_RECOVERY_EN defined, an all-zero state seen on an enabled edge SHALL reload the effective seed on that edge.
REQ-023 Without LFSR_LOCKUP_RECOVERY_EN, an all-zero state SHALL persist until reset, with no extra logic inferred.

Verification
REQ-024 WIDTH=3, TAPS=101: hold reset low, release it and raise enable -> lfsr_out = 111, 110, 101, 010, 100, 001, 011, 111 on successive edges.
REQ-025 Drop enable for 3 cycles mid-sequence while lfsr_out = 010 -> lfsr_out stays 010, then resumes at 100.
REQ-026 Assert reset between clk edges while lfsr_out = 100 -> lfsr_out = 111 immediately, without waiting for an edge.
REQ-027 Defaults (WIDTH=8, TAPS=B8), run 300 enabled cycles -> the state returns to FF exactly at cycle 255 and never reads 00.
REQ-028 Force the state to 000 with enable high -> 111 on the next edge when LFSR_LOCKUP_RECOVERY_EN is defined, otherwise it remains 000.
REQ-029 Instantiate with SEED=0 -> the post-reset value is all-ones.
